// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard scheduler: forwarding selects, scheduler states,
// and the ResultSrc encoding that marks a load in E.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEM_WAIT,
        HZ_ERROR
    } hz_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Forwarding select for one E-stage operand; the younger M-stage producer wins over W.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] i_rs,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_m,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_w,
    input  logic                     i_reg_write_m,
    input  logic                     i_reg_write_w,
    output fwd_sel_t                 o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage RV32I pipeline: forwarding, load-use, flush, memory freeze, watchdog.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     PCSrcE,
    input  logic                     MemReqM,
    input  logic                     MemReadyM,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushW,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     MemErr,
    output logic [31:0]              StallCnt,
    output logic [31:0]              FlushCnt
);

    localparam int WDOG_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         r_state;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_mem_err;

    fwd_sel_t          w_fwd_a;
    fwd_sel_t          w_fwd_b;
    logic              w_lw_stall;
    logic              w_mem_stall;

    forward_unit #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
        .i_rs          (Rs1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_a)
    );

    forward_unit #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
        .i_rs          (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_sel         (w_fwd_b)
    );

    assign w_lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mem_stall = MemReqM && !MemReadyM;

    // The watchdog saturates into ERROR instead of wrapping; only RST leaves ERROR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= HZ_RUN;
            r_wdog    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (w_mem_stall) begin
                        r_state <= HZ_MEM_WAIT;
                        r_wdog  <= WDOG_W'(1);
                    end
                end
                HZ_MEM_WAIT: begin
                    if (MemReadyM) begin
                        r_state <= HZ_RUN;
                        r_wdog  <= '0;
                    end else if (r_wdog == WDOG_W'(MEM_TIMEOUT)) begin
                        r_state   <= HZ_ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                HZ_ERROR: begin
                    r_state <= HZ_ERROR;
                end
                default: begin
                    r_state <= HZ_RUN;
                end
            endcase
        end
    end

    assign MemErr = r_mem_err;

    // Memory ready releases the freeze in the same cycle, so stall depends on inputs, not state alone.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (RST) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if ((r_state == HZ_ERROR) || w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign ForwardAE = RST ? FWD_RF : w_fwd_a;
    assign ForwardBE = RST ? FWD_RF : w_fwd_b;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF || StallD || StallE || StallM) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (FlushE) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: rule-level reference model checked every cycle
// plus directed vectors with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int MT = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [31:0]   StallCnt, FlushCnt;

    pipeline_hazard_ctrl #(.ADDRESS_WIDTH(AW), .MEM_TIMEOUT(MT)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: consecutive waiting cycles and a sticky trap flag.
    int          m_run  = 0;
    bit          m_err  = 1'b0;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    function automatic logic [1:0] fwd_exp(input logic [AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Bundle layout: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, FwdA[1:0], FwdB[1:0], MemErr}
    function automatic logic [11:0] exp_bundle();
        logic [3:0] st;
        logic fd, fe, fw;
        bit ms, lw;
        ms = MemReqM && !MemReadyM;
        lw = (ResultSrcE == 2'b01) && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
        st = 4'b0000; fd = 1'b0; fe = 1'b0; fw = 1'b0;
        if (RST) return {4'b0000, 3'b111, 4'b0000, m_err};
        if (m_err || ms) begin st = 4'b1111; fw = 1'b1; end
        else if (PCSrcE) begin fd = 1'b1; fe = 1'b1; end
        else if (lw) begin st = 4'b1100; fe = 1'b1; end
        return {st, fd, fe, fw, fwd_exp(Rs1E), fwd_exp(Rs2E), m_err};
    endfunction

    function automatic logic [11:0] dut_bundle();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr};
    endfunction

    always @(posedge CLK) begin
        logic [11:0] e;
        e = exp_bundle();
        if (RST) begin
            m_run = 0; m_err = 1'b0; m_scnt = '0; m_fcnt = '0;
        end else begin
            if (|e[11:8]) m_scnt = m_scnt + 32'd1;
            if (e[6])     m_fcnt = m_fcnt + 32'd1;
            if (!m_err) begin
                if (MemReqM && !MemReadyM) m_run++;
                else m_run = 0;
                if (m_run == MT + 1) m_err = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            check("outputs", {20'd0, dut_bundle()}, {20'd0, exp_bundle()});
            check("StallCnt", StallCnt, PERF ? m_scnt : 32'd0);
            check("FlushCnt", FlushCnt, PERF ? m_fcnt : 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        tick();
        checking = 1'b1;
        @(negedge CLK); check("reset_outputs", {20'd0, dut_bundle()}, 32'b0000_111_00_00_0);
        tick();
        RST = 1'b0;

        // Forwarding
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd9; Rs2E = 5'd9;
        @(negedge CLK); check("fwdA_mem", {30'd0, ForwardAE}, 32'h2); check("fwdB_wb", {30'd0, ForwardBE}, 32'h1);
        tick(); RdW = 5'd5; Rs2E = 5'd5;
        @(negedge CLK); check("fwdA_m_beats_w", {30'd0, ForwardAE}, 32'h2);
        tick(); RdM = 5'd0; RegWriteW = 1'b0;
        @(negedge CLK); check("fwdA_rdm_zero", {30'd0, ForwardAE}, 32'h0);
        tick(); RegWriteW = 1'b1; RdW = 5'd0; Rs2E = 5'd0;
        @(negedge CLK); check("fwdB_x0", {30'd0, ForwardBE}, 32'h0);

        // Load-use stall, then bubble
        tick(); clear_inputs(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        @(negedge CLK); check("lw_stall", {20'd0, dut_bundle()}, 32'b1100_010_00_00_0);
        tick(); clear_inputs();
        @(negedge CLK); check("lw_bubble", {20'd0, dut_bundle()}, 32'b0000_000_00_00_0);

        // Taken branch overrides load-use
        tick(); ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        @(negedge CLK); check("branch_over_lw", {20'd0, dut_bundle()}, 32'b0000_110_00_00_0);

        // Memory freeze with a pending branch, released by ready
        tick(); clear_inputs(); MemReqM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); check("mem_freeze", {20'd0, dut_bundle()}, 32'b1111_001_00_00_0);
            tick();
        end
        MemReadyM = 1'b1;
        @(negedge CLK); check("mem_release_branch", {20'd0, dut_bundle()}, 32'b0000_110_00_00_0);
        tick(); clear_inputs();

        // Perf counter scenario from a fresh reset
        RST = 1'b1; tick(); RST = 1'b0;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        tick(); clear_inputs();
        tick(); MemReqM = 1'b1;
        tick(); tick(); tick(); MemReadyM = 1'b1;
        tick(); clear_inputs();
        @(negedge CLK);
        check("perf_stall", StallCnt, PERF ? 32'd4 : 32'd0);
        check("perf_flush", FlushCnt, PERF ? 32'd1 : 32'd0);

        // Boundary: ready arrives on the last allowed wait cycle
        tick(); MemReqM = 1'b1;
        for (int i = 0; i < MT; i++) tick();
        MemReadyM = 1'b1;
        tick(); clear_inputs();
        @(negedge CLK); check("no_trap_at_limit", {20'd0, dut_bundle()}, 32'b0000_000_00_00_0);

        // Timeout trap
        tick(); MemReqM = 1'b1;
        for (int i = 0; i < MT; i++) tick();
        @(negedge CLK); check("memerr_before_timeout", {31'd0, MemErr}, 32'd0);
        tick();
        @(negedge CLK); check("memerr_set", {31'd0, MemErr}, 32'd1);
        tick(); MemReqM = 1'b0; PCSrcE = 1'b1;
        @(negedge CLK); check("error_holds_stalls", {20'd0, dut_bundle()}, 32'b1111_001_00_00_1);
        tick(); clear_inputs(); RST = 1'b1;
        tick(); RST = 1'b0;
        @(negedge CLK); check("error_cleared", {20'd0, dut_bundle()}, 32'b0000_000_00_00_0);

        // Reset in the middle of a wait
        tick(); MemReqM = 1'b1;
        tick(); tick(); RST = 1'b1; MemReqM = 1'b0;
        tick(); RST = 1'b0;
        tick();
        @(negedge CLK); check("rst_aborts_wait", {20'd0, dut_bundle()}, 32'b0000_000_00_00_0);

        tick();
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
